serial_receiver: RTL and testbench

Receive end of the calculator's serial link. Deserializes the 32-bit MSB-first frame driven on `DataOut`/`DoutValid`/`ClkTx` by `calc_binar` back into a parallel word in the `Clk` domain. Splits the word into ALU fields and presents it with a valid/ack handshake plus error and overrun status. Sits in the host/checker side of the design, as the counterpart of `serial_tranceiver`.

---
 rtl/calc_pkg.sv | 32 +++
 rtl/bit_synchronizer.sv | 37 +++
 rtl/serial_receiver.sv | 157 +++++++++++++++
 tb/tb_serial_receiver.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and field layout for the calculator serial link receiver.
package calc_pkg;

  // Receiver sequencing states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECV     = 2'd1,
    COMPLETE = 2'd2
  } rx_state_e;

  localparam int FRAME_BITS = 32;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  // Field placement inside the received word (bit 31 arrives first).
  localparam int OPA_LSB  = 0;
  localparam int OPA_W    = 8;
  localparam int OPB_LSB  = 8;
  localparam int OPB_W    = 8;
  localparam int RES_LSB  = 16;
  localparam int RES_W    = 8;
  localparam int SEL_LSB  = 24;
  localparam int SEL_W    = 4;
  localparam int FLAG_LSB = 28;
  localparam int FLAG_W   = 4;

  // Bit positions inside the flag field.
  localparam int FLAG_ZERO      = 0;
  localparam int FLAG_CARRY     = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 3;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer with a trailing copy of the output for edge detection.
module bit_synchronizer #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic q_prev
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;
  logic             prev_q;
  logic             prev_d;

  // Shift the asynchronous input along the chain and keep last cycle's output.
  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d};
    prev_d = sync_q[DEPTH-1];
  end

  // Chain and history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q      = sync_q[DEPTH-1];
  assign q_prev = prev_q;

endmodule

// File: rtl/serial_receiver.sv
// Deserializes the MSB-first calculator frame into a held word with a
// valid/ack handshake, truncation pulse and sticky overrun status.
//
// state    | meaning
// IDLE     | waiting for a strobe with SerValid high (and re-armed)
// RECV     | shifting in bits on each strobe
// COMPLETE | one cycle: hand the frame over or record an overrun
module serial_receiver
  import calc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  SerClk,
  input  logic                  SerIn,
  input  logic                  SerValid,
  input  logic                  RxAck,
  output logic [FRAME_BITS-1:0] RxWord,
  output logic [OPA_W-1:0]      RxOpA,
  output logic [OPB_W-1:0]      RxOpB,
  output logic [RES_W-1:0]      RxResult,
  output logic [SEL_W-1:0]      RxSel,
  output logic [FLAG_W-1:0]     RxFlag,
  output logic                  RxValid,
  output logic                  RxError,
  output logic                  RxOverrun,
  output logic                  RxBusy
);

  logic sclk_s, sclk_p;
  logic sdat_s, sdat_p;
  logic sval_s, sval_p;
  logic strobe;
  logic unused_prev;

  rx_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [FRAME_BITS-1:0] word_q, word_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  error_q, error_d;
  logic                  armed_q, armed_d;

  // All three lines share the same depth so a bit and its qualifier stay aligned.
  bit_synchronizer #(.DEPTH(SYNC_STAGES)) u_sync_clk (
    .clk(Clk), .rst(Reset), .d(SerClk), .q(sclk_s), .q_prev(sclk_p)
  );
  bit_synchronizer #(.DEPTH(SYNC_STAGES)) u_sync_dat (
    .clk(Clk), .rst(Reset), .d(SerIn), .q(sdat_s), .q_prev(sdat_p)
  );
  bit_synchronizer #(.DEPTH(SYNC_STAGES)) u_sync_val (
    .clk(Clk), .rst(Reset), .d(SerValid), .q(sval_s), .q_prev(sval_p)
  );

  // Only the clock line needs its history; the others exist for alignment.
  assign unused_prev = sdat_p ^ sval_p;

  // Falling edge of the bit clock lands in the middle of the data bit.
  assign strobe = sclk_p & ~sclk_s;

  // Next-state, shift/count and handshake logic.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    count_d   = count_q;
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    error_d   = 1'b0;
    armed_d   = armed_q;

    if (!sval_s) armed_d = 1'b1;

    if (RxAck && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (strobe && sval_s && armed_q) begin
          shift_d = {{(FRAME_BITS-1){1'b0}}, sdat_s};
          count_d = CNT_W'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        // The last bit is taken even if the qualifier drops on the same strobe.
        if (strobe && (sval_s || count_q == CNT_W'(FRAME_BITS - 1))) begin
          shift_d = {shift_q[FRAME_BITS-2:0], sdat_s};
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(FRAME_BITS - 1)) state_d = COMPLETE;
        end else if (!sval_s) begin
          error_d = 1'b1;
          shift_d = '0;
          count_d = '0;
          armed_d = 1'b0;
          state_d = IDLE;
        end
      end
      COMPLETE: begin
        if (!valid_q || RxAck) begin
          word_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        shift_d = '0;
        count_d = '0;
        armed_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        shift_d = '0;
        count_d = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      count_q   <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      error_q   <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      error_q   <= error_d;
      armed_q   <= armed_d;
    end
  end

  assign RxWord    = word_q;
  assign RxOpA     = word_q[OPA_LSB +: OPA_W];
  assign RxOpB     = word_q[OPB_LSB +: OPB_W];
  assign RxResult  = word_q[RES_LSB +: RES_W];
  assign RxSel     = word_q[SEL_LSB +: SEL_W];
  assign RxFlag    = word_q[FLAG_LSB +: FLAG_W];
  assign RxValid   = valid_q;
  assign RxError   = error_q;
  assign RxOverrun = overrun_q;
  assign RxBusy    = (state_q != IDLE);

endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: table of ALU frames plus hand-written corner cases.
module tb_serial_receiver;
  import calc_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, SerClk, SerIn, SerValid, RxAck;
  logic [31:0] RxWord;
  logic [7:0]  RxOpA, RxOpB, RxResult;
  logic [3:0]  RxSel, RxFlag;
  logic        RxValid, RxError, RxOverrun, RxBusy;

  serial_receiver #(.SYNC_STAGES(2)) dut (
    .Clk(Clk), .Reset(Reset), .SerClk(SerClk), .SerIn(SerIn),
    .SerValid(SerValid), .RxAck(RxAck), .RxWord(RxWord), .RxOpA(RxOpA),
    .RxOpB(RxOpB), .RxResult(RxResult), .RxSel(RxSel), .RxFlag(RxFlag),
    .RxValid(RxValid), .RxError(RxError), .RxOverrun(RxOverrun), .RxBusy(RxBusy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  res;
    logic [3:0]  sel;
    logic [3:0]  flag;
    logic [31:0] exp_word;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          rises = 0;
  int          err_pulses = 0;
  int          err_wide = 0;
  bit          monitor_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard side: every rising RxValid consumes one expected word.
  initial begin
    logic rv_prev = 1'b0;
    logic er_prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (monitor_on) begin
        if (RxValid && !rv_prev) begin
          rises++;
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL sb_word: RxValid rose with nothing expected, got 0x%08h", RxWord);
          end else begin
            chk("sb_word", RxWord, exp_q.pop_front());
          end
        end
        if (RxError) err_pulses++;
        if (RxError && er_prev) err_wide++;
      end
      rv_prev = RxValid;
      er_prev = RxError;
    end
  end

  // Drives nbits of w at a 4-cycle bit period, then closes the frame.
  // rv3/rv4 are RxValid three and four cycles after the last falling edge.
  task automatic send_frame(input logic [31:0] w, input int nbits, input bit ack_cpl,
                            input bit rst_mid, output logic rv3, output logic rv4);
    rv3 = 1'b0;
    rv4 = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge Clk); SerClk = 1'b1; SerValid = 1'b1; SerIn = w[31-i];
      @(negedge Clk);
      @(negedge Clk); SerClk = 1'b0;
      @(negedge Clk);
    end
    @(negedge Clk);
    if (rst_mid) begin
      Reset = 1'b1; SerValid = 1'b0; SerIn = 1'b0;
    end else begin
      SerClk = 1'b1; SerValid = 1'b0; SerIn = 1'b0;
      @(negedge Clk);
      rv3 = RxValid;
      if (ack_cpl) RxAck = 1'b1;
      @(negedge Clk);
      rv4 = RxValid;
      RxAck = 1'b0; SerClk = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
    end
  endtask

  task automatic do_ack();
    @(negedge Clk); RxAck = 1'b1;
    @(negedge Clk); RxAck = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic        rv3, rv4;
    int          base;

    vecs[0] = '{8'h0F, 8'h01, 8'h10, 4'd0, 4'd0, 32'h0010010F};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 4'd1, 4'(1 << FLAG_UNDERFLOW), 32'h81FE0503};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 4'd0, 4'(1 << FLAG_CARRY), 32'h20FEFFFF};
    vecs[3] = '{8'h80, 8'h80, 8'h00, 4'd2,
                4'((1 << FLAG_OVERFLOW) | (1 << FLAG_ZERO)), 32'h52008080};

    Reset = 1'b1; SerClk = 1'b0; SerIn = 1'b0; SerValid = 1'b0; RxAck = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_word", RxWord, 0);
    chk("rst_valid", RxValid, 0);
    chk("rst_busy", RxBusy, 0);
    chk("rst_ovr", RxOverrun, 0);
    chk("rst_err", RxError, 0);
    Reset = 1'b0;
    monitor_on = 1'b1;
    repeat (4) @(negedge Clk);

    // Table: each frame is received, fields sliced, then acknowledged.
    for (int i = 0; i < 4; i++) begin
      base = rises;
      w = {vecs[i].flag, vecs[i].sel, vecs[i].res, vecs[i].b, vecs[i].a};
      exp_q.push_back(vecs[i].exp_word);
      send_frame(w, 32, 1'b0, 1'b0, rv3, rv4);
      chk($sformatf("v%0d_lat_early", i), rv3, 0);
      chk($sformatf("v%0d_lat", i), rv4, 1);
      chk($sformatf("v%0d_rises", i), rises - base, 1);
      chk($sformatf("v%0d_opa", i), RxOpA, vecs[i].a);
      chk($sformatf("v%0d_opb", i), RxOpB, vecs[i].b);
      chk($sformatf("v%0d_res", i), RxResult, vecs[i].res);
      chk($sformatf("v%0d_sel", i), RxSel, vecs[i].sel);
      chk($sformatf("v%0d_flag", i), RxFlag, vecs[i].flag);
      do_ack();
      chk($sformatf("v%0d_acked", i), RxValid, 0);
    end
    chk("table_err", err_pulses, 0);

    // Overrun: second frame dropped while first is held.
    exp_q.push_back(32'hA1B2C3D4);
    send_frame(32'hA1B2C3D4, 32, 1'b0, 1'b0, rv3, rv4);
    send_frame(32'h11223344, 32, 1'b0, 1'b0, rv3, rv4);
    chk("ovr_word", RxWord, 32'hA1B2C3D4);
    chk("ovr_valid", RxValid, 1);
    chk("ovr_flag", RxOverrun, 1);
    do_ack();
    chk("ovr_ack_valid", RxValid, 0);
    chk("ovr_ack_flag", RxOverrun, 0);

    // Truncation after 12 bits while a word is held.
    exp_q.push_back(32'h5A5A0F0F);
    send_frame(32'h5A5A0F0F, 32, 1'b0, 1'b0, rv3, rv4);
    base = err_pulses;
    send_frame(32'hFFFFFFFF, 12, 1'b0, 1'b0, rv3, rv4);
    repeat (4) @(negedge Clk);
    chk("trunc_pulses", err_pulses - base, 1);
    chk("trunc_wide", err_wide, 0);
    chk("trunc_valid", RxValid, 1);
    chk("trunc_word", RxWord, 32'h5A5A0F0F);
    do_ack();
    exp_q.push_back(32'hC0FFEE01);
    send_frame(32'hC0FFEE01, 32, 1'b0, 1'b0, rv3, rv4);
    chk("post_trunc_valid", RxValid, 1);
    do_ack();

    // Ack in the COMPLETE cycle of a back-to-back frame.
    exp_q.push_back(32'h13572468);
    send_frame(32'h13572468, 32, 1'b0, 1'b0, rv3, rv4);
    send_frame(32'h9ABCDEF0, 32, 1'b1, 1'b0, rv3, rv4);
    chk("cplack_word", RxWord, 32'h9ABCDEF0);
    chk("cplack_valid", RxValid, 1);
    chk("cplack_ovr", RxOverrun, 0);
    do_ack();

    // Reset after 20 bits while a word is held.
    exp_q.push_back(32'h0BADF00D);
    send_frame(32'h0BADF00D, 32, 1'b0, 1'b0, rv3, rv4);
    base = err_pulses;
    send_frame(32'hDEADBEEF, 20, 1'b0, 1'b1, rv3, rv4);
    #1;
    chk("rmid_word", RxWord, 0);
    chk("rmid_opa", RxOpA, 0);
    chk("rmid_valid", RxValid, 0);
    chk("rmid_busy", RxBusy, 0);
    chk("rmid_ovr", RxOverrun, 0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    chk("rmid_err", err_pulses - base, 0);
    exp_q.push_back(32'h76543210);
    send_frame(32'h76543210, 32, 1'b0, 1'b0, rv3, rv4);
    chk("rmid_next_valid", rv4, 1);
    chk("rmid_next_res", RxResult, 8'h54);
    do_ack();

    repeat (4) @(negedge Clk);
    chk("sb_drained", exp_q.size(), 0);
    chk("total_err", err_pulses, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
